// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back path.
package regfile_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t        rd;
    logic [XLEN-1:0] wd;
  } wb_req_t;

  typedef enum logic {LAST_EX = 1'b0, LAST_LD = 1'b1} last_e;
endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set at issue,
// cleared when the write reaches the register file port.
module wb_scoreboard #(
  parameter int NREG = 32,
  parameter int IW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [IW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [IW-1:0] clr_idx,
  input  logic [IW-1:0] rs1,
  input  logic [IW-1:0] rs2,
  output logic          rs1_busy,
  output logic          rs2_busy
);
  logic [NREG-1:0] pending_d, pending_q;

  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_idx] = 1'b0;
    // Set is applied last so a new producer outranks a retiring one.
    if (set_en && set_idx != '0) pending_d[set_idx] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign rs1_busy = pending_q[rs1];
  assign rs2_busy = pending_q[rs2];
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter (execute vs load) feeding the register file
// write port, plus RAW scoreboard. REGFILE_WB_ARB_DEBUG_EN adds a low-priority debug writer.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int XLEN = regfile_pkg::XLEN,
  parameter int NREG = regfile_pkg::NREG,
  localparam int IW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [IW-1:0]   ex_rd,
  input  logic [XLEN-1:0] ex_wd,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [IW-1:0]   ld_rd,
  input  logic [XLEN-1:0] ld_wd,
`ifdef REGFILE_WB_ARB_DEBUG_EN
  input  logic            dbg_valid,
  output logic            dbg_ready,
  input  logic [IW-1:0]   dbg_rd,
  input  logic [XLEN-1:0] dbg_wd,
`endif
  input  logic            iss_valid,
  input  logic [IW-1:0]   iss_rd,
  input  logic [IW-1:0]   rs1,
  input  logic [IW-1:0]   rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rf_we,
  output logic [IW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_wd
);
  last_e           last_d, last_q;
  logic            ex_gnt, ld_gnt, dbg_gnt;
  logic [IW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_wd;
  logic            rf_we_d, rf_we_q;
  logic [IW-1:0]   rf_rd_d, rf_rd_q;
  logic [XLEN-1:0] rf_wd_d, rf_wd_q;

  always_comb begin
    // Grants are gated by rst_n so nothing is accepted while in reset.
    ex_gnt  = rst_n && ex_valid && (!ld_valid || last_q == LAST_LD);
    ld_gnt  = rst_n && ld_valid && (!ex_valid || last_q == LAST_EX);
    dbg_gnt = 1'b0;
    sel_rd  = ex_rd;
    sel_wd  = ex_wd;
    if (ld_gnt) begin
      sel_rd = ld_rd;
      sel_wd = ld_wd;
    end
`ifdef REGFILE_WB_ARB_DEBUG_EN
    dbg_gnt = rst_n && dbg_valid && !ex_valid && !ld_valid;
    if (dbg_gnt) begin
      sel_rd = dbg_rd;
      sel_wd = dbg_wd;
    end
`endif
    last_d = last_q;
    if (ex_gnt)      last_d = LAST_EX;
    else if (ld_gnt) last_d = LAST_LD;

    // x0 writes are accepted but never reach the port.
    rf_we_d = (ex_gnt || ld_gnt || dbg_gnt) && sel_rd != '0;
    rf_rd_d = rf_we_d ? sel_rd : rf_rd_q;
    rf_wd_d = rf_we_d ? sel_wd : rf_wd_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= LAST_LD;
      rf_we_q <= 1'b0;
      rf_rd_q <= '0;
      rf_wd_q <= '0;
    end else begin
      last_q  <= last_d;
      rf_we_q <= rf_we_d;
      rf_rd_q <= rf_rd_d;
      rf_wd_q <= rf_wd_d;
    end
  end

  assign ex_ready = ex_gnt;
  assign ld_ready = ld_gnt;
`ifdef REGFILE_WB_ARB_DEBUG_EN
  assign dbg_ready = dbg_gnt;
`endif
  assign rf_we = rf_we_q;
  assign rf_rd = rf_rd_q;
  assign rf_wd = rf_wd_q;

  wb_scoreboard #(.NREG(NREG), .IW(IW)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (iss_valid),
    .set_idx  (iss_rd),
    .clr_en   (rf_we_q),
    .clr_idx  (rf_rd_q),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: handshake, round-robin, x0 drop,
// scoreboard timing, set/clear collision and mid-flight reset.
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ld_valid, iss_valid;
  logic        ex_ready, ld_ready;
  logic [4:0]  ex_rd, ld_rd, iss_rd, rs1, rs2, rf_rd;
  logic [31:0] ex_wd, ld_wd, rf_wd;
  logic        rs1_busy, rs2_busy, rf_we;
`ifdef REGFILE_WB_ARB_DEBUG_EN
  logic        dbg_valid = 1'b0;
  logic        dbg_ready;
  logic [4:0]  dbg_rd = '0;
  logic [31:0] dbg_wd = '0;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_wd(ex_wd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_wd(ld_wd),
`ifdef REGFILE_WB_ARB_DEBUG_EN
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_rd(dbg_rd), .dbg_wd(dbg_wd),
`endif
    .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then driven and outputs sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    ex_valid = 1'b1; ld_valid = 1'b0; iss_valid = 1'b0;
    ex_rd = 5'd3; ld_rd = '0; iss_rd = '0; rs1 = '0; rs2 = '0;
    ex_wd = '0; ld_wd = '0;
    #2;
    chk("rst_ex_ready", ex_ready, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_rd", rf_rd, 0);
    chk("rst_rf_wd", rf_wd, 0);
    ex_valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();

    // Single request
    ex_valid = 1'b1; ex_rd = 5'd5; ex_wd = 32'hDEADBEEF;
    #1 chk("single_ex_ready", ex_ready, 1);
    step();
    ex_valid = 1'b0;
    chk("single_we", rf_we, 1);
    chk("single_rd", rf_rd, 5);
    chk("single_wd", rf_wd, 32'hDEADBEEF);

    // Lone ld write so the next tie goes to ex
    ld_valid = 1'b1; ld_rd = 5'd3; ld_wd = 32'h33;
    #1 chk("lone_ld_ready", ld_ready, 1);
    step();
    ld_valid = 1'b0;
    chk("lone_ld_rd", rf_rd, 3);

    // Contention: ex, ld, ex, ld
    ex_valid = 1'b1; ex_rd = 5'd1; ex_wd = 32'h11;
    ld_valid = 1'b1; ld_rd = 5'd2; ld_wd = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("cont_ex_ready%0d", i), ex_ready, (i % 2 == 0));
      chk($sformatf("cont_ld_ready%0d", i), ld_ready, (i % 2 == 1));
      step();
      chk($sformatf("cont_we%0d", i), rf_we, 1);
      chk($sformatf("cont_rd%0d", i), rf_rd, (i % 2 == 0) ? 1 : 2);
    end
    ex_valid = 1'b0; ld_valid = 1'b0;
    step();
    chk("idle_we", rf_we, 0);
    chk("idle_rd_hold", rf_rd, 2);

    // x0 drop
    ld_valid = 1'b1; ld_rd = 5'd0; ld_wd = 32'h1234;
    #1 chk("x0_ld_ready", ld_ready, 1);
    step();
    ld_valid = 1'b0;
    chk("x0_we", rf_we, 0);
    chk("x0_rd_hold", rf_rd, 2);
    chk("x0_wd_hold", rf_wd, 32'h22);

    // Scoreboard set / clear latency
    iss_valid = 1'b1; iss_rd = 5'd7;
    step();
    iss_valid = 1'b0; rs1 = 5'd7; rs2 = 5'd8;
    #1;
    chk("sb_rs1_busy", rs1_busy, 1);
    chk("sb_rs2_idle", rs2_busy, 0);
    ex_valid = 1'b1; ex_rd = 5'd7; ex_wd = 32'h77;
    step();
    ex_valid = 1'b0;
    chk("sb_we_n1", rf_we, 1);
    chk("sb_busy_n1", rs1_busy, 1);
    step();
    chk("sb_busy_n2", rs1_busy, 0);

    // x0 issue never marks pending
    iss_valid = 1'b1; iss_rd = 5'd0;
    step();
    iss_valid = 1'b0; rs2 = 5'd0;
    #1 chk("sb_x0_busy", rs2_busy, 0);

    // Set/clear collision on reg 9
    iss_valid = 1'b1; iss_rd = 5'd9;
    step();
    iss_valid = 1'b0;
    ex_valid = 1'b1; ex_rd = 5'd9; ex_wd = 32'h99;
    step();
    ex_valid = 1'b0;
    chk("coll_we", rf_we, 1);
    chk("coll_rd", rf_rd, 9);
    iss_valid = 1'b1; iss_rd = 5'd9;
    step();
    iss_valid = 1'b0; rs1 = 5'd9;
    #1 chk("coll_busy", rs1_busy, 1);

    // Reset mid-flight after an ex accept (last = EX before reset)
    iss_valid = 1'b1; iss_rd = 5'd12;
    step();
    iss_valid = 1'b0;
    ex_valid = 1'b1; ex_rd = 5'd4; ex_wd = 32'h44;
    step();
    ex_valid = 1'b0;
    chk("mid_we_pre", rf_we, 1);
    rst_n = 1'b0;
    #1 chk("mid_we_async", rf_we, 0);
    step();
    rst_n = 1'b1;
    rs1 = 5'd12; rs2 = 5'd9;
    #1;
    chk("mid_rs1_busy", rs1_busy, 0);
    chk("mid_rs2_busy", rs2_busy, 0);
    ex_valid = 1'b1; ex_rd = 5'd1; ex_wd = 32'hA1;
    ld_valid = 1'b1; ld_rd = 5'd2; ld_wd = 32'hB2;
    #1;
    chk("mid_tie_ex", ex_ready, 1);
    chk("mid_tie_ld", ld_ready, 0);
    step();
    ex_valid = 1'b0; ld_valid = 1'b0;
    chk("mid_tie_rd", rf_rd, 1);
    chk("mid_tie_wd", rf_wd, 32'hA1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
